io_port_host: RTL and testbench
===============================

Name: io_port_host

Overview:
Host-side peer of the processor's I/O port and interrupt pins; it sits outside the CPU top level.
- Input side: buffers bytes pushed by a host agent in an input FIFO, presents the head byte on In_port, and raises the int line so the CPU's ISR consumes it.
- Output side: captures each byte the CPU writes to Out_port into an output FIFO drained by the host over a valid/ready interface.
- Used in system benches and FPGA wrappers.

Parameters:
WIDTH, 8, data byte width; must match the CPU port width
DEPTH, 4, entries per FIFO; power of 2, >= 2
INT_W, 2, cycles the int pulse is held high; >= 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
h_in_valid  in  1  host offers h_in_data
h_in_data  in  WIDTH  byte for the CPU
h_in_ready  out  1  input FIFO not full
In_port  out  WIDTH  head of input FIFO; 0 when empty
int  out  1  interrupt request to CPU
cpu_in_ack  in  1  one-cycle pulse: CPU consumed In_port (IN instruction at write-back)
Out_port  in  WIDTH  CPU output port value
cpu_out_stb  in  1  one-cycle pulse: Out_port loaded this cycle (out_ld at write-back)
HLT  in  1  CPU halted flag
int_enable  in  1  host permits interrupt generation
h_out_valid  out  1  output FIFO not empty
h_out_data  out  WIDTH  head of output FIFO; 0 when empty
h_out_ready  in  1  host accepts h_out_data
err  out  2  sticky: [1] output overflow, [0] input underflow
err_clr  in  1  clears err (synchronous)
in_count  out  clog2(DEPTH)+1  input FIFO occupancy
out_count  out  clog2(DEPTH)+1  output FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous): both FIFOs empty, pointers and counts 0.
  - Outputs at reset: int=0, err=0, In_port=0, h_out_data=0, h_out_valid=0, h_in_ready=1.
  - The FSM returns to IDLE even mid-pulse or mid-wait.
- Input FIFO:
  - Push when h_in_valid & h_in_ready.
  - Pop when cpu_in_ack & in_count!=0.
  - Push and pop in the same cycle leave the count unchanged.
  - cpu_in_ack with in_count==0 sets err[0], even if a push lands in the same cycle. No pop occurs.
  - In_port is read from registers only (no combinational path from h_in_data). A pushed byte is visible on the cycle after the push.
- Output FIFO:
  - Push Out_port on cpu_out_stb.
  - Pop when h_out_valid & h_out_ready.
  - A strobe while full and not popping the same cycle drops the byte and sets err[1].
  - A strobe while full with a same-cycle pop is accepted.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from count.
- err_clr has priority below a same-cycle set: the set wins.
- Interrupt FSM:
  - IDLE: if in_count!=0 & int_enable & !HLT -> PULSE, with cnt=INT_W-1 and int=1.
  - PULSE: int=1. If cnt==0 -> WAIT, else cnt-1.
  - WAIT: int=0. On cpu_in_ack -> GAP.
  - GAP: int=0 for one cycle -> IDLE. This guarantees an int low gap of at least 1 cycle between requests.
  - HLT=1 in any state forces int=0 and moves to IDLE on the next edge. Queued data stays.
  - int_enable falling during PULSE does not truncate the pulse. int_enable is sampled only in IDLE.
  - Exactly one interrupt is issued per byte consumed. Remaining bytes trigger a new pulse after GAP.
- All outputs other than In_port, h_out_data, h_in_ready, h_out_valid and counts are registered. Those five are decoded from registers.

Test Plan:
1. Reset mid-operation: push 0xA5, assert rst low during PULSE -> int=0 immediately; in_count=0; In_port=0x00 after release.
2. Push 0x3C with int_enable=1 -> next cycle In_port=0x3C. int high exactly 2 cycles (INT_W=2), then low. Pulse cpu_in_ack -> in_count=0, FSM in IDLE after GAP.
3. Push 0x11,0x22,0x33,0x44 back-to-back -> h_in_ready=0 after 4th; fifth push stalls. Two ack-gated interrupts deliver 0x11 then 0x22 in order, with an int low gap of at least 1 cycle.
4. Output capture: five cpu_out_stb with Out_port=0x01..0x05, h_out_ready=0 -> out_count=4, err[1]=1. Host drains 0x01..0x04. err_clr -> err=0.
5. Underflow: cpu_in_ack with FIFO empty -> err[0]=1, in_count stays 0, no pointer movement.
6. HLT=1 with 2 queued bytes -> int stays 0. HLT=0 -> pulse within 2 cycles, In_port=first byte.

Source files
------------

// File: rtl/io_port_host.sv
// rtl/io_port_host.sv - host-side peer of the CPU I/O port: input/output byte FIFOs and interrupt FSM
module io_port_host #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int INT_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       h_in_valid,
  input  logic [WIDTH-1:0]           h_in_data,
  output logic                       h_in_ready,
  output logic [WIDTH-1:0]           In_port,
  output logic                       int_req,
  input  logic                       cpu_in_ack,
  input  logic [WIDTH-1:0]           Out_port,
  input  logic                       cpu_out_stb,
  input  logic                       HLT,
  input  logic                       int_enable,
  output logic                       h_out_valid,
  output logic [WIDTH-1:0]           h_out_data,
  input  logic                       h_out_ready,
  output logic [1:0]                 err,
  input  logic                       err_clr,
  output logic [$clog2(DEPTH):0]     in_count,
  output logic [$clog2(DEPTH):0]     out_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = (INT_W > 1) ? $clog2(INT_W) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_GAP} state_t;

  logic [WIDTH-1:0] in_mem_q [DEPTH];
  logic [WIDTH-1:0] in_mem_d [DEPTH];
  logic [WIDTH-1:0] out_mem_q [DEPTH];
  logic [WIDTH-1:0] out_mem_d [DEPTH];
  logic [AW-1:0]    in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [AW-1:0]    out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [CW-1:0]    in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [1:0]       err_q, err_d;
  logic             in_push, in_pop, out_push, out_pop, underflow, overflow;

  state_t           state_q;
  logic [CNTW-1:0]  cnt_q;
  logic             int_q;

  assign h_in_ready  = (in_cnt_q != FULL);
  assign h_out_valid = (out_cnt_q != '0);
  assign In_port     = (in_cnt_q != '0) ? in_mem_q[in_rd_q] : '0;
  assign h_out_data  = (out_cnt_q != '0) ? out_mem_q[out_rd_q] : '0;
  assign in_count    = in_cnt_q;
  assign out_count   = out_cnt_q;
  assign err         = err_q;
  assign int_req     = int_q;

  assign in_push   = h_in_valid & h_in_ready;
  assign in_pop    = cpu_in_ack & (in_cnt_q != '0);
  assign underflow = cpu_in_ack & (in_cnt_q == '0);
  assign out_pop   = h_out_valid & h_out_ready;
  // A full output FIFO still accepts a strobe when the host frees a slot in the same cycle.
  assign out_push  = cpu_out_stb & ((out_cnt_q != FULL) | out_pop);
  assign overflow  = cpu_out_stb & (out_cnt_q == FULL) & ~out_pop;

  always_comb begin
    in_mem_d  = in_mem_q;
    out_mem_d = out_mem_q;
    in_wr_d   = in_wr_q;
    in_rd_d   = in_rd_q;
    out_wr_d  = out_wr_q;
    out_rd_d  = out_rd_q;
    if (in_push) begin
      in_mem_d[in_wr_q] = h_in_data;
      in_wr_d           = in_wr_q + AW'(1);
    end
    if (in_pop) in_rd_d = in_rd_q + AW'(1);
    if (out_push) begin
      out_mem_d[out_wr_q] = Out_port;
      out_wr_d            = out_wr_q + AW'(1);
    end
    if (out_pop) out_rd_d = out_rd_q + AW'(1);
    in_cnt_d  = in_cnt_q + CW'(in_push) - CW'(in_pop);
    out_cnt_d = out_cnt_q + CW'(out_push) - CW'(out_pop);
    err_d     = err_clr ? 2'b00 : err_q;
    err_d     = err_d | {overflow, underflow};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        in_mem_q[i]  <= '0;
        out_mem_q[i] <= '0;
      end
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= '0;
    end else begin
      in_mem_q  <= in_mem_d;
      out_mem_q <= out_mem_d;
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  // One request per consumed byte; GAP forces int low for a cycle before the next request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      int_q   <= 1'b0;
    end else if (HLT) begin
      state_q <= S_IDLE;
      int_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if ((in_cnt_q != '0) && int_enable) begin
            state_q <= S_PULSE;
            cnt_q   <= CNTW'(INT_W - 1);
            int_q   <= 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            state_q <= S_WAIT;
            int_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        S_WAIT: begin
          int_q <= 1'b0;
          if (cpu_in_ack) state_q <= S_GAP;
        end
        default: begin
          int_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_host.sv
// tb/tb_io_port_host.sv - scoreboard bench for io_port_host
module tb_io_port_host;

  logic       clk = 1'b0;
  logic       rst;
  logic       h_in_valid, h_in_ready, int_req, cpu_in_ack, cpu_out_stb;
  logic       HLT, int_enable, h_out_valid, h_out_ready, err_clr;
  logic [7:0] h_in_data, In_port, Out_port, h_out_data;
  logic [1:0] err;
  logic [2:0] in_count, out_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] in_q[$];
  logic [7:0] out_q[$];

  io_port_host #(.WIDTH(8), .DEPTH(4), .INT_W(2)) dut (
    .clk(clk), .rst(rst),
    .h_in_valid(h_in_valid), .h_in_data(h_in_data), .h_in_ready(h_in_ready),
    .In_port(In_port), .int_req(int_req), .cpu_in_ack(cpu_in_ack),
    .Out_port(Out_port), .cpu_out_stb(cpu_out_stb), .HLT(HLT), .int_enable(int_enable),
    .h_out_valid(h_out_valid), .h_out_data(h_out_data), .h_out_ready(h_out_ready),
    .err(err), .err_clr(err_clr), .in_count(in_count), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input logic [7:0] d);
    h_in_valid = 1'b1;
    h_in_data  = d;
    if (h_in_ready) in_q.push_back(d);
    tick();
    h_in_valid = 1'b0;
  endtask

  task automatic ack();
    cpu_in_ack = 1'b1;
    tick();
    cpu_in_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    h_in_valid = 0; h_in_data = 0; cpu_in_ack = 0; Out_port = 0; cpu_out_stb = 0;
    HLT = 0; int_enable = 0; h_out_ready = 0; err_clr = 0;
    tick(); tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL reset_int got=%b exp=0", int_req); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", err); end
    checks++; if (In_port !== 8'h00) begin errors++; $display("FAIL reset_in_port got=%h exp=00", In_port); end
    checks++; if (h_out_data !== 8'h00 || h_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out got=%h/%b exp=00/0", h_out_data, h_out_valid); end
    checks++; if (h_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", h_in_ready); end
    checks++; if (in_count !== 3'd0 || out_count !== 3'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", in_count, out_count); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_pulse();
    int n = 0;
    int_enable = 1'b1;
    push_in(8'hA5);
    while (!int_req && n < 20) begin tick(); n++; end
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL midrst_pulse_start got=%b exp=1", int_req); end
    rst = 1'b0;
    #1;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL midrst_int got=%b exp=0", int_req); end
    checks++; if (in_count !== 3'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", in_count); end
    in_q.delete();
    int_enable = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (In_port !== 8'h00) begin errors++; $display("FAIL midrst_in_port got=%h exp=00", In_port); end
  endtask

  task automatic test_single_irq();
    int n = 0;
    int hi = 0;
    logic seen;
    int_enable = 1'b1;
    push_in(8'h3C);
    checks++; if (In_port !== 8'h3C) begin errors++; $display("FAIL single_in_port got=%h exp=3c", In_port); end
    while (!int_req && n < 20) begin tick(); n++; end
    checks++; if (In_port !== in_q[0]) begin errors++; $display("FAIL single_head got=%h exp=%h", In_port, in_q[0]); end
    void'(in_q.pop_front());
    while (int_req && hi < 10) begin hi++; tick(); end
    checks++; if (hi != 2) begin errors++; $display("FAIL single_pulse_width got=%0d exp=2", hi); end
    ack();
    checks++; if (in_count !== 3'd0) begin errors++; $display("FAIL single_count got=%0d exp=0", in_count); end
    seen = int_req;
    for (int i = 0; i < 4; i++) begin tick(); seen = seen | int_req; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL single_idle_int got=%b exp=0", seen); end
    int_enable = 1'b0;
  endtask

  task automatic serve_irqs(input int nbytes, input string tag);
    for (int i = 0; i < nbytes; i++) begin
      int n = 0;
      while (!int_req && n < 20) begin tick(); n++; end
      checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL %s_irq%0d_timeout got=%b exp=1", tag, i, int_req); end
      if (i > 0) begin
        checks++; if (n < 1) begin errors++; $display("FAIL %s_gap%0d got=%0d exp>=1", tag, i, n); end
      end
      checks++; if (In_port !== in_q[0]) begin errors++; $display("FAIL %s_data%0d got=%h exp=%h", tag, i, In_port, in_q[0]); end
      void'(in_q.pop_front());
      n = 0;
      while (int_req && n < 20) begin tick(); n++; end
      ack();
    end
  endtask

  task automatic test_back_to_back();
    int_enable = 1'b0;
    push_in(8'h11); push_in(8'h22); push_in(8'h33); push_in(8'h44);
    checks++; if (h_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got=%b exp=0", h_in_ready); end
    push_in(8'h55);
    checks++; if (in_count !== 3'd4) begin errors++; $display("FAIL b2b_stall_count got=%0d exp=4", in_count); end
    int_enable = 1'b1;
    serve_irqs(4, "b2b");
    checks++; if (in_count !== 3'd0) begin errors++; $display("FAIL b2b_drained got=%0d exp=0", in_count); end
    int_enable = 1'b0;
    tick(); tick();
  endtask

  task automatic out_strobe(input logic [7:0] d);
    Out_port    = d;
    cpu_out_stb = 1'b1;
    if (out_q.size() < 4 || (h_out_ready && h_out_valid)) out_q.push_back(d);
    if (h_out_ready && h_out_valid) void'(out_q.pop_front());
    tick();
    cpu_out_stb = 1'b0;
  endtask

  task automatic drain_out(input string tag);
    int n = 0;
    h_out_ready = 1'b1;
    while (h_out_valid && n < 10) begin
      checks++; if (h_out_data !== out_q[0]) begin errors++; $display("FAIL %s_drain%0d got=%h exp=%h", tag, n, h_out_data, out_q[0]); end
      void'(out_q.pop_front());
      tick(); n++;
    end
    h_out_ready = 1'b0;
    checks++; if (out_count !== 3'd0 || out_q.size() != 0) begin errors++; $display("FAIL %s_drain_end got=%0d left=%0d exp=0", tag, out_count, out_q.size()); end
  endtask

  task automatic test_output();
    h_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) out_strobe(8'(i));
    checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL out_count got=%0d exp=4", out_count); end
    checks++; if (err !== 2'b10) begin errors++; $display("FAIL out_overflow got=%b exp=10", err); end
    drain_out("out");
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL out_err_clr got=%b exp=00", err); end
    for (int i = 0; i < 4; i++) out_strobe(8'h10 + 8'(i));
    h_out_ready = 1'b1;
    checks++; if (h_out_data !== out_q[0]) begin errors++; $display("FAIL out_full_pop_head got=%h exp=%h", h_out_data, out_q[0]); end
    out_strobe(8'h14);
    h_out_ready = 1'b0;
    checks++; if (out_count !== 3'd4 || err !== 2'b00) begin errors++; $display("FAIL out_full_pop got=%0d/%b exp=4/00", out_count, err); end
    drain_out("outfp");
  endtask

  task automatic test_underflow();
    int_enable = 1'b0;
    cpu_in_ack = 1'b1; err_clr = 1'b1;
    tick();
    cpu_in_ack = 1'b0; err_clr = 1'b0;
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL uf_set_wins got=%b exp=01", err); end
    checks++; if (in_count !== 3'd0) begin errors++; $display("FAIL uf_count got=%0d exp=0", in_count); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    cpu_in_ack = 1'b1;
    push_in(8'h77);
    cpu_in_ack = 1'b0;
    checks++; if (err !== 2'b01 || in_count !== 3'd1) begin errors++; $display("FAIL uf_with_push got=%b/%0d exp=01/1", err, in_count); end
    checks++; if (In_port !== in_q[0]) begin errors++; $display("FAIL uf_ptr got=%h exp=%h", In_port, in_q[0]); end
    void'(in_q.pop_front());
    ack();
    checks++; if (in_count !== 3'd0 || In_port !== 8'h00) begin errors++; $display("FAIL uf_pop got=%0d/%h exp=0/00", in_count, In_port); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_halt();
    logic seen;
    int n = 0;
    HLT = 1'b1; int_enable = 1'b1;
    push_in(8'h9A); push_in(8'hB7);
    seen = int_req;
    for (int i = 0; i < 5; i++) begin tick(); seen = seen | int_req; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL halt_int got=%b exp=0", seen); end
    checks++; if (in_count !== 3'd2) begin errors++; $display("FAIL halt_count got=%0d exp=2", in_count); end
    HLT = 1'b0;
    while (!int_req && n < 20) begin tick(); n++; end
    checks++; if (n > 2 || int_req !== 1'b1) begin errors++; $display("FAIL halt_release_latency got=%0d exp<=2", n); end
    serve_irqs(2, "halt");
    int_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_pulse();
    test_single_irq();
    test_back_to_back();
    test_output();
    test_underflow();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
